// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer scheduler types and default frame geometry
package fb_pkg;
   typedef enum logic [1:0] {WAIT, CLEAR, GRANT} fb_sched_state_t;
   localparam int HOR_ACTIVE_PIXELS = 640;
   localparam int VER_ACTIVE_PIXELS = 480;
   localparam int PIXELS = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS;
endpackage

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: shares the frame_buffer write port between producers, latching the source at swap; FB_WRITE_SCHEDULER_CLEAR_EN adds a zero-fill CLEAR state
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int NUM_SRC           = 2,
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS),
   parameter int OVR_WIDTH         = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ce,
   input  logic [$clog2(NUM_SRC)-1:0]    sel,
   input  logic                          swap,
   input  logic [NUM_SRC-1:0]            src_wr_en,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_wr_addr,
   input  logic [NUM_SRC-1:0]            src_wr_data,
   input  logic [NUM_SRC-1:0]            src_done,
   output logic [NUM_SRC-1:0]            src_gnt,
   output logic                          fb_wr_en,
   output logic [ADDR_WIDTH-1:0]         fb_wr_addr,
   output logic                          fb_wr_data,
   output logic                          busy,
   output logic [$clog2(NUM_SRC)-1:0]    cur_src,
   output logic [OVR_WIDTH-1:0]          overrun_cnt
);
   localparam int SW = $clog2(NUM_SRC);
   fb_sched_state_t state_q, state_d;
   logic [SW-1:0] cur_src_q, cur_src_d;
   logic [OVR_WIDTH-1:0] ovr_q, ovr_d;
   logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
   logic fb_en_q, fb_en_d, fb_data_q, fb_data_d;
   logic done_cur, accept, overrun;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
   localparam int PIX = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS;
   logic first_q, first_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif
   always_comb begin
      done_cur  = src_done[cur_src_q];
      // done and swap together behave like a swap arriving in WAIT
      accept    = ce && swap && (state_q == WAIT || (state_q == GRANT && done_cur));
      overrun   = ce && swap && state_q != WAIT && !accept;
      state_d   = state_q;
      cur_src_d = cur_src_q;
      ovr_d     = (overrun && ovr_q != '1) ? ovr_q + 1'b1 : ovr_q;
      fb_en_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
      first_d    = first_q;
      clr_addr_d = clr_addr_q;
      if (ce && state_q == CLEAR) begin
         fb_en_d    = 1'b1;
         fb_addr_d  = clr_addr_q;
         fb_data_d  = 1'b0;
         clr_addr_d = (clr_addr_q == ADDR_WIDTH'(PIX-1)) ? '0 : clr_addr_q + 1'b1;
         state_d    = (clr_addr_q == ADDR_WIDTH'(PIX-1)) ? GRANT : CLEAR;
      end
`endif
      if (ce && state_q == GRANT) begin
         fb_en_d   = src_wr_en[cur_src_q];
         fb_addr_d = src_wr_addr[cur_src_q*ADDR_WIDTH +: ADDR_WIDTH];
         fb_data_d = src_wr_data[cur_src_q];
         state_d   = done_cur ? WAIT : GRANT;
      end
      if (accept) begin
         cur_src_d = sel;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
         state_d = (first_q || sel != cur_src_q) ? CLEAR : GRANT;
         first_d = 1'b0;
`else
         state_d = GRANT;
`endif
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT;
         cur_src_q <= '0;
         ovr_q     <= '0;
         fb_en_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= 1'b0;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
         first_q    <= 1'b1;
         clr_addr_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cur_src_q <= cur_src_d;
         ovr_q     <= ovr_d;
         fb_en_q   <= fb_en_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
         first_q    <= first_d;
         clr_addr_q <= clr_addr_d;
`endif
      end
   end
   assign src_gnt     = (state_q == GRANT) ? {{(NUM_SRC-1){1'b0}}, 1'b1} << cur_src_q : '0;
   assign fb_wr_en    = fb_en_q;
   assign fb_wr_addr  = fb_addr_q;
   assign fb_wr_data  = fb_data_q;
   assign busy        = state_q != WAIT;
   assign cur_src     = cur_src_q;
   assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench on a 16x4 frame; covers both builds of FB_WRITE_SCHEDULER_CLEAR_EN
module tb_fb_write_scheduler;
   localparam int AW = 6;
   localparam int PIX = 64;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1, sel = 1'b0, swap = 1'b0;
   logic [1:0] src_wr_en = '0, src_wr_data = '0, src_done = '0, src_gnt;
   logic [2*AW-1:0] src_wr_addr = '0;
   logic fb_wr_en, fb_wr_data, busy, cur_src;
   logic [AW-1:0] fb_wr_addr;
   logic [7:0] overrun_cnt;
   logic [AW:0] sb_q[$];
   logic sb_off = 1'b0;
   int n_chk = 0, n_fail = 0;
   fb_write_scheduler #(
      .NUM_SRC(2), .HOR_ACTIVE_PIXELS(16), .VER_ACTIVE_PIXELS(4), .ADDR_WIDTH(AW), .OVR_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .sel(sel), .swap(swap), .src_wr_en(src_wr_en),
      .src_wr_addr(src_wr_addr), .src_wr_data(src_wr_data), .src_done(src_done),
      .src_gnt(src_gnt), .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
      .busy(busy), .cur_src(cur_src), .overrun_cnt(overrun_cnt)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (fb_wr_en && !sb_off) begin
         if (sb_q.size() == 0) check("unexpected_wr", {26'd0, fb_wr_addr}, 32'hffff_ffff);
         else check("fb_wr", {25'd0, fb_wr_addr, fb_wr_data}, {25'd0, sb_q.pop_front()});
      end
   end
   task automatic go_swap(input logic s, input bit exp_clear, input logic [1:0] exp_gnt);
      int n = 0;
      sel = s;
      swap = 1'b1;
      if (exp_clear) for (int i = 0; i < PIX; i++) sb_q.push_back({AW'(i), 1'b0});
      tick();
      swap = 1'b0;
      while (src_gnt == 2'b00 && n < 500) begin
         tick();
         n++;
      end
      check("gnt", src_gnt, exp_gnt);
      check("gnt_latency", n, exp_clear ? PIX : 0);
      check("cur_src", cur_src, s);
   endtask
   task automatic write_burst(input logic s, input int cnt);
      logic [AW-1:0] a;
      logic d;
      for (int i = 0; i < cnt; i++) begin
         a = AW'($urandom_range(0, PIX-1));
         d = 1'($urandom);
         src_wr_en = s ? {1'b1, 1'($urandom)} : {1'($urandom), 1'b1};
         src_wr_addr = s ? {a, ~a} : {~a, a};
         src_wr_data = s ? {d, ~d} : {~d, d};
         sb_q.push_back({a, d});
         tick();
      end
      src_wr_en = '0;
   endtask
   initial begin
      #3;
      check("rst_gnt", src_gnt, 0);
      check("rst_wr_en", fb_wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_cur_src", cur_src, 0);
      check("rst_ovr", overrun_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      go_swap(1'b1, CLR, 2'b10);
      src_wr_en = 2'b11;
      src_wr_addr = {6'd37, 6'd5};
      src_wr_data = 2'b10;
      sb_q.push_back({6'd37, 1'b1});
      tick();
      src_wr_en = '0;
      write_burst(1'b1, 8);
      src_done = 2'b10;
      swap = 1'b1;
      tick();
      src_done = '0;
      swap = 1'b0;
      check("done_swap_ovr", overrun_cnt, 0);
      check("done_swap_gnt", src_gnt, 2'b10);
      check("done_swap_busy", busy, 1);
      src_done = 2'b01;
      tick();
      src_done = '0;
      check("other_done_gnt", src_gnt, 2'b10);
      sel = 1'b0;
      tick();
      check("sel_tog0", cur_src, 1);
      sel = 1'b1;
      tick();
      sel = 1'b0;
      tick();
      check("sel_tog2", cur_src, 1);
      ce = 1'b0;
      src_wr_en = 2'b10;
      swap = 1'b1;
      src_done = 2'b10;
      tick();
      swap = 1'b0;
      src_done = '0;
      src_wr_en = '0;
      ce = 1'b1;
      check("ce_ovr", overrun_cnt, 0);
      check("ce_gnt", src_gnt, 2'b10);
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check("ovr_one", overrun_cnt, 1);
      check("ovr_gnt", src_gnt, 2'b10);
      swap = 1'b1;
      repeat (300) tick();
      swap = 1'b0;
      check("ovr_sat", overrun_cnt, 255);
      write_burst(1'b1, 4);
      src_done = 2'b10;
      tick();
      src_done = '0;
      check("done_gnt", src_gnt, 0);
      check("done_busy", busy, 0);
      go_swap(1'b0, CLR, 2'b01);
      write_burst(1'b0, 8);
      src_done = 2'b01;
      tick();
      src_done = '0;
      sb_off = 1'b1;
      sel = 1'b1;
      swap = 1'b1;
      tick();
      swap = 1'b0;
      src_wr_en = 2'b10;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", src_gnt, 0);
      check("mid_rst_wr_en", fb_wr_en, 0);
      check("mid_rst_busy", busy, 0);
      src_wr_en = '0;
      tick();
      rst_n = 1'b1;
      tick();
      sb_off = 1'b0;
      go_swap(1'b1, CLR, 2'b10);
      write_burst(1'b1, 3);
      tick();
      tick();
      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
